// File: rtl/data_mem_unit.sv
// Byte-addressable data memory with byte-lane store merging and a sticky fault record; DMEM_STATS_EN adds load/store counters.
// Latency: loads are combinational (0 cycles); stores commit at the rising edge ending the access cycle.
// Backpressure: none; one access is accepted every cycle unconditionally.
module data_mem_unit #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic        err_flag,
    output logic [31:0] err_addr,
`ifdef DMEM_STATS_EN
    output logic [15:0] ld_count,
    output logic [15:0] st_count,
`endif
    input  logic        err_clr
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rel_addr;
    logic [AW-1:0] word_idx;
    logic [1:0]    offset;
    logic          is_b, is_h, is_w, legal;
    logic          misaligned, in_range, access, fault;
    logic          ld_ok, st_ok;
    logic [31:0]   rd_word, rd_shift, rd_mask;
    logic [3:0]    lane_en;
    logic [31:0]   wr_rep;

    // BASE_ADDR is span-aligned, so the relative address low bits equal the byte offset.
    assign rel_addr = MEM_addr - BASE_ADDR;
    assign word_idx = rel_addr[AW+1:2];
    assign offset   = rel_addr[1:0];
    assign in_range = rel_addr < SPAN;

    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        is_w = 1'b0;
        case (MEM_type)
            3'b000, 3'b100: is_b = 1'b1;
            3'b001, 3'b101: is_h = 1'b1;
            3'b010:         is_w = 1'b1;
            default:        ;
        endcase
    end

    assign legal      = is_b | is_h | is_w;
    assign misaligned = (is_h & offset[0]) | (is_w & (offset != 2'b00));
    assign access     = MEM_rd_en | MEM_wr_en;
    assign fault      = access & (~legal | misaligned | ~in_range | (MEM_rd_en & MEM_wr_en));
    assign ld_ok      = MEM_rd_en & ~MEM_wr_en & ~fault;
    assign st_ok      = MEM_wr_en & ~MEM_rd_en & ~fault;

    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {offset, 3'b000};
    assign rd_mask  = is_b ? 32'h0000_00FF : (is_h ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    assign MEM_data = ld_ok ? (rd_shift & rd_mask) : 32'h0;

    assign lane_en = is_b ? (4'b0001 << offset) : (is_h ? (4'b0011 << offset) : 4'b1111);
    assign wr_rep  = is_b ? {4{MEM_WR_out[7:0]}} : (is_h ? {2{MEM_WR_out[15:0]}} : MEM_WR_out);

    // Array has no reset; a store is dropped if reset is held across its edge.
    always_ff @(posedge CLK) begin
        if (rst && st_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            err_flag <= 1'b0;
            err_addr <= 32'h0;
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_addr <= 32'h0;
        end else if (fault && !err_flag) begin
            err_flag <= 1'b1;
            err_addr <= MEM_addr;
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            ld_count <= 16'h0;
            st_count <= 16'h0;
        end else begin
            if (ld_ok && (ld_count != 16'hFFFF)) ld_count <= ld_count + 16'd1;
            if (st_ok && (st_count != 16'hFFFF)) st_count <= st_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized and directed bench for data_mem_unit against a byte-array reference model.
module tb_data_mem_unit;

    localparam int          DW   = 64;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] MEM_addr = '0;
    logic [31:0] MEM_WR_out = '0;
    logic [2:0]  MEM_type = '0;
    logic        MEM_rd_en = 1'b0;
    logic        MEM_wr_en = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] MEM_data;
    logic        err_flag;
    logic [31:0] err_addr;
`ifdef DMEM_STATS_EN
    logic [15:0] ld_count;
    logic [15:0] st_count;
`endif

    data_mem_unit #(.DEPTH_WORDS(DW), .BASE_ADDR(BASE)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .MEM_addr   (MEM_addr),
        .MEM_WR_out (MEM_WR_out),
        .MEM_type   (MEM_type),
        .MEM_rd_en  (MEM_rd_en),
        .MEM_wr_en  (MEM_wr_en),
        .MEM_data   (MEM_data),
        .err_flag   (err_flag),
        .err_addr   (err_addr),
`ifdef DMEM_STATS_EN
        .ld_count   (ld_count),
        .st_count   (st_count),
`endif
        .err_clr    (err_clr)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  mref [0:4*DW-1];
    logic        m_err   = 1'b0;
    logic [31:0] m_eaddr = 32'h0;
    int          m_ld    = 0;
    int          m_st    = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic int acc_size(input logic [2:0] t);
        case (t)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit is_fault(input logic rd, input logic wr, input logic [2:0] t, input logic [31:0] a);
        longint rel;
        int     sz;
        if (!rd && !wr) return 1'b0;
        sz  = acc_size(t);
        rel = longint'(a) - longint'(BASE);
        if (sz == 0 || (rd && wr)) return 1'b1;
        if ((a % sz) != 0) return 1'b1;
        if (rel < 0 || rel >= 4 * DW) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_data(input logic rd, input logic wr, input logic [2:0] t, input logic [31:0] a);
        logic [31:0] v;
        int          base_i;
        v = 32'h0;
        if (!rd || wr || is_fault(rd, wr, t, a)) return v;
        base_i = int'(a - BASE);
        for (int k = 0; k < acc_size(t); k++) v = v | (32'(mref[base_i + k]) << (8 * k));
        return v;
    endfunction

    task automatic model_edge(input logic rd, input logic wr, input logic [2:0] t, input logic [31:0] a,
                              input logic [31:0] d, input logic clr);
        bit f;
        int base_i;
        if (!rst) begin
            m_err = 1'b0; m_eaddr = 32'h0; m_ld = 0; m_st = 0;
            return;
        end
        f = is_fault(rd, wr, t, a);
        if (clr) begin
            m_err = 1'b0; m_eaddr = 32'h0;
        end else if (f && !m_err) begin
            m_err = 1'b1; m_eaddr = a;
        end
        if (!f && rd && !wr && m_ld < 65535) m_ld++;
        if (!f && wr && !rd) begin
            base_i = int'(a - BASE);
            for (int k = 0; k < acc_size(t); k++) mref[base_i + k] = d[8*k +: 8];
            if (m_st < 65535) m_st++;
        end
    endtask

    // Called just after a rising edge: drives one access, compares at the falling edge, advances the model.
    task automatic cycle(input logic rd, input logic wr, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic clr, output logic [31:0] got);
        MEM_rd_en = rd; MEM_wr_en = wr; MEM_type = t; MEM_addr = a; MEM_WR_out = d; err_clr = clr;
        @(negedge CLK);
        got = MEM_data;
        chk("mem_data", MEM_data, exp_data(rd, wr, t, a));
        chk("err_flag", {31'b0, err_flag}, {31'b0, m_err});
        chk("err_addr", err_addr, m_eaddr);
`ifdef DMEM_STATS_EN
        chk("ld_count", {16'b0, ld_count}, 32'(m_ld));
        chk("st_count", {16'b0, st_count}, 32'(m_st));
`endif
        @(posedge CLK);
        model_edge(rd, wr, t, a, d, clr);
        #1;
    endtask

    initial begin
        logic [31:0] g;
        logic [2:0]  legal_t [5];
        int          r;
        logic [31:0] a;
        legal_t = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        #3;
        chk("reset_err_flag", {31'b0, err_flag}, 32'h0);
        chk("reset_err_addr", err_addr, 32'h0);
`ifdef DMEM_STATS_EN
        chk("reset_ld_count", {16'b0, ld_count}, 32'h0);
        chk("reset_st_count", {16'b0, st_count}, 32'h0);
`endif
        @(negedge CLK); rst = 1'b1;
        @(posedge CLK); #1;

        for (int w = 0; w < DW; w++) cycle(1'b0, 1'b1, 3'b010, BASE + 32'(w * 4), $urandom, 1'b0, g);

        cycle(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, g);
        cycle(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, g);
        chk("lw_after_sw", g, 32'hDEADBEEF);
        chk("no_err_after_sw", {31'b0, err_flag}, 32'h0);

        cycle(1'b0, 1'b1, 3'b000, 32'h12, 32'h000000AA, 1'b0, g);
        cycle(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, g);
        chk("lw_after_sb", g, 32'hDEAABEEF);
        cycle(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, g);
        chk("lbu_13", g, 32'h000000DE);

        cycle(1'b0, 1'b1, 3'b001, 32'h11, 32'h00001234, 1'b0, g);
        chk("sh_misalign_flag", {31'b0, err_flag}, 32'h1);
        chk("sh_misalign_addr", err_addr, 32'h11);
        cycle(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, g);
        chk("lw_unchanged", g, 32'hDEAABEEF);
        cycle(1'b1, 1'b0, 3'b010, 32'h7, 32'h0, 1'b0, g);
        chk("err_addr_sticky", err_addr, 32'h11);

        cycle(1'b1, 1'b0, 3'b010, BASE + 32'(4 * DW), 32'h0, 1'b1, g);
        chk("oob_ld_data", g, 32'h0);
        chk("clr_flag", {31'b0, err_flag}, 32'h0);
        chk("clr_addr", err_addr, 32'h0);

        cycle(1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0, g);
        chk("dual_data", g, 32'h0);
        chk("dual_flag", {31'b0, err_flag}, 32'h1);
        rst = 1'b0;
        m_err = 1'b0; m_eaddr = 32'h0; m_ld = 0; m_st = 0;
        #1;
        chk("async_rst_flag", {31'b0, err_flag}, 32'h0);
        chk("async_rst_addr", err_addr, 32'h0);
        #1;
        cycle(1'b0, 1'b1, 3'b010, 32'h24, 32'h55555555, 1'b0, g);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 1'b0, g);
        cycle(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, g);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 9) < 8) ? BASE + 32'($urandom_range(0, 4 * DW - 1))
                                          : BASE + 32'($urandom_range(4 * DW, 4 * DW + 15));
            cycle(r < 4 || r == 9, (r >= 4 && r < 8) || r == 9,
                  ($urandom_range(0, 9) < 8) ? legal_t[$urandom_range(0, 4)] : 3'($urandom_range(0, 7)),
                  a, $urandom, $urandom_range(0, 19) == 0, g);
        end

`ifdef DMEM_STATS_EN
        rst = 1'b0;
        m_err = 1'b0; m_eaddr = 32'h0; m_ld = 0; m_st = 0;
        @(negedge CLK); rst = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0, g);
        cycle(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, g);
        cycle(1'b1, 1'b0, 3'b000, 32'h5, 32'h0, 1'b0, g);
        cycle(1'b1, 1'b0, 3'b010, 32'h3, 32'h0, 1'b0, g);
        chk("st_count_3", {16'b0, st_count}, 32'd3);
        chk("ld_count_2", {16'b0, ld_count}, 32'd2);
        for (int i = 0; i < 65533; i++) cycle(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, g);
        chk("ld_count_full", {16'b0, ld_count}, 32'h0000FFFF);
        cycle(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, g);
        chk("ld_count_sat", {16'b0, ld_count}, 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
